// File: rtl/lc3_bus_arbiter.sv
// Round-robin bus arbiter and gate sequencer for the LC-3 datapath bus.
// Owns the one-hot drive enables, muxes the owning source and strobes the CC load.
module lc3_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,
  input  logic [N_REQ-1:0]      i_Req,
  input  logic [N_REQ-1:0]      i_Lock,
  input  logic [N_REQ-1:0]      i_SetCC,
  input  logic [16*N_REQ-1:0]   i_Data,
  output logic [N_REQ-1:0]      o_Gate,
  output logic                  o_Grant_Valid,
  output logic [15:0]           o_Bus,
  output logic                  o_LD_CC_Control
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    ptr_r;
  logic [CW-1:0]    cnt_r;

  logic [PW-1:0]    owner_idx_s;
  logic [PW-1:0]    rel_ptr_s;
  logic             others_s;
  logic             cont_s;
  logic [N_REQ-1:0] win_idle_s;
  logic [N_REQ-1:0] win_rel_s;
  logic [15:0]      bus_s;

  // First requester at or above start, wrapping; the start slot has top priority.
  function automatic logic [N_REQ-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                   input logic [PW-1:0]    start);
    logic [N_REQ-1:0] grant;
    logic             found;
    logic [PW-1:0]    idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(start) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

  // Owner decode, hold decision and the two candidate winners.
  always_comb begin
    owner_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      owner_idx_s = owner_idx_s | (o_Gate[k] ? PW'(k) : '0);
    end
    rel_ptr_s  = (owner_idx_s == PW'(N_REQ - 1)) ? '0 : owner_idx_s + PW'(1);
    others_s   = |(i_Req & ~o_Gate);
    cont_s     = (|(i_Req & i_Lock & o_Gate)) &&
                 ((cnt_r < CW'(MAX_HOLD)) || !others_s);
    win_idle_s = pick_winner(i_Req, ptr_r);
    win_rel_s  = pick_winner(i_Req, rel_ptr_s);
  end

  // Arbitration FSM: grant from idle, hold under lock, or hand off back-to-back.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_r <= IDLE;
      o_Gate  <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|i_Req) begin
            o_Gate  <= win_idle_s;
            cnt_r   <= CW'(1);
            state_r <= OWN;
          end
        end
        OWN: begin
          if (cont_s) begin
            if (cnt_r < CW'(MAX_HOLD)) begin
              cnt_r <= cnt_r + CW'(1);
            end
          end else begin
            // The releasing owner becomes the lowest-priority slot.
            ptr_r <= rel_ptr_s;
            if (|i_Req) begin
              o_Gate <= win_rel_s;
              cnt_r  <= CW'(1);
            end else begin
              o_Gate  <= '0;
              cnt_r   <= '0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          o_Gate  <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // One-hot bus mux as an OR of AND terms.
  always_comb begin
    bus_s = 16'h0000;
    for (int k = 0; k < N_REQ; k++) begin
      bus_s = bus_s | ({16{o_Gate[k]}} & i_Data[16*k +: 16]);
    end
  end

  assign o_Bus           = bus_s;
  assign o_Grant_Valid   = |o_Gate;
  assign o_LD_CC_Control = |(o_Gate & i_SetCC);

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Scoreboard bench for lc3_bus_arbiter: an integer-level reference model
// predicts each bus cycle; a negedge monitor pops and compares.
module tb_lc3_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic        i_CLK;
  logic        i_RST_n;
  logic [3:0]  i_Req, i_Lock, i_SetCC;
  logic [63:0] i_Data;
  logic [3:0]  o_Gate;
  logic        o_Grant_Valid;
  logic [15:0] o_Bus;
  logic        o_LD_CC_Control;

  lc3_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .i_CLK(i_CLK), .i_RST_n(i_RST_n), .i_Req(i_Req), .i_Lock(i_Lock),
    .i_SetCC(i_SetCC), .i_Data(i_Data), .o_Gate(o_Gate),
    .o_Grant_Valid(o_Grant_Valid), .o_Bus(o_Bus), .o_LD_CC_Control(o_LD_CC_Control)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  typedef struct packed {
    logic [3:0]  gate;
    logic        valid;
    logic [15:0] bus;
    logic        ldcc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model: owner index (-1 = bus idle), scan pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic int first_from(input logic [3:0] req, input int start);
    for (int i = 0; i < N; i++) begin
      if (req[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step();
    bit others, keep;
    if (m_owner < 0) begin
      m_owner = first_from(i_Req, m_ptr);
      m_hold  = (m_owner >= 0) ? 1 : 0;
    end else begin
      others = (i_Req & ~(4'b0001 << m_owner)) != 4'b0000;
      keep   = i_Req[m_owner] && i_Lock[m_owner] && (m_hold < MAXH || !others);
      if (keep) begin
        m_hold = (m_hold < MAXH) ? m_hold + 1 : MAXH;
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = first_from(i_Req, m_ptr);
        m_hold  = (m_owner >= 0) ? 1 : 0;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.gate  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.valid = (m_owner >= 0);
    e.bus   = (m_owner >= 0) ? i_Data[16*m_owner +: 16] : 16'h0000;
    e.ldcc  = (m_owner >= 0) ? i_SetCC[m_owner] : 1'b0;
    sb.push_back(e);
  endtask

  // One bus cycle: model consumes the inputs sampled at this edge, then new inputs are applied.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] s, input logic [63:0] d);
    @(posedge i_CLK);
    if (!i_RST_n) model_reset();
    else model_step();
    #1;
    i_Req = r; i_Lock = l; i_SetCC = s; i_Data = d;
    push_exp();
  endtask

  function automatic logic [2:0] nzp(input logic [15:0] v);
    return v[15] ? 3'b100 : ((v == 16'h0000) ? 3'b010 : 3'b001);
  endfunction

  // Monitor: compare every presented bus cycle against the scoreboard.
  always @(negedge i_CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_gate",  32'(o_Gate),          32'(e.gate));
      chk("sb_valid", 32'(o_Grant_Valid),   32'(e.valid));
      chk("sb_bus",   32'(o_Bus),           32'(e.bus));
      chk("sb_ldcc",  32'(o_LD_CC_Control), 32'(e.ldcc));
    end
  end

  logic [63:0] dd;
  logic [3:0]  exp_rr [4];

  initial begin
    dd = {16'h3333, 16'h8000, 16'h1111, 16'h0AAA};
    exp_rr[0] = 4'b0010; exp_rr[1] = 4'b0100; exp_rr[2] = 4'b1000; exp_rr[3] = 4'b0001;
    i_RST_n = 1'b0;
    i_Req = 4'b1111; i_Lock = 4'b0000; i_SetCC = 4'b0000; i_Data = dd;

    // Reset with every source requesting.
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0000, 4'b0000, dd);
      chk("rst_gate", 32'(o_Gate), 32'h0);
      chk("rst_bus",  32'(o_Bus),  32'h0);
    end
    i_RST_n = 1'b1;
    step(4'b1111, 4'b0000, 4'b0000, dd);
    chk("first_grant_pc", 32'(o_Gate), 32'h1);

    // Round robin without lock.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) step(4'b1100, 4'b0100, 4'b0100, dd);
      else        step(4'b1111, 4'b0000, 4'b0000, dd);
      chk("rr_gate", 32'(o_Gate), 32'(exp_rr[i]));
    end

    // Hold cap: locked ALU versus MDR.
    for (int i = 0; i < 4; i++) begin
      step(4'b1100, 4'b0100, 4'b0100, dd);
      chk("hold_alu", 32'(o_Gate), 32'h4);
    end
    step(4'b0100, 4'b0100, 4'b0100, dd);
    chk("hold_mdr", 32'(o_Gate), 32'h8);

    // Sole locked requester holds indefinitely; CC strobe on 16'h8000.
    for (int i = 0; i < 8; i++) begin
      step(4'b0100, 4'b0100, 4'b0100, dd);
      chk("sole_alu", 32'(o_Gate), 32'h4);
    end
    chk("cc_bus",  32'(o_Bus), 32'h8000);
    chk("cc_ld",   32'(o_LD_CC_Control), 32'h1);
    chk("cc_nzp",  32'(nzp(o_Bus)), 32'h4);
    step(4'b0010, 4'b0000, 4'b0100, dd);
    step(4'b1000, 4'b1000, 4'b0100, dd);
    chk("mar_gate", 32'(o_Gate), 32'h2);
    chk("mar_ld",   32'(o_LD_CC_Control), 32'h0);
    chk("mar_bus",  32'(o_Bus), 32'h1111);

    // Owner withdraw: MDR locked, drops request after one cycle.
    step(4'b0000, 4'b0000, 4'b0000, dd);
    chk("wd_mdr", 32'(o_Gate), 32'h8);
    step(4'b1010, 4'b0000, 4'b0000, dd);
    chk("wd_idle", 32'(o_Gate), 32'h0);
    chk("wd_valid", 32'(o_Grant_Valid), 32'h0);
    step(4'b0001, 4'b0001, 4'b0001, dd);
    chk("wd_ptr0", 32'(o_Gate), 32'h2);

    // Async reset during a PC grant.
    step(4'b0001, 4'b0001, 4'b0001, dd);
    chk("pre_rst_gate", 32'(o_Gate), 32'h1);
    chk("pre_rst_ld",   32'(o_LD_CC_Control), 32'h1);
    #1;
    i_RST_n = 1'b0;
    #1;
    sb.delete();
    model_reset();
    chk("arst_gate", 32'(o_Gate), 32'h0);
    chk("arst_bus",  32'(o_Bus), 32'h0);
    chk("arst_ld",   32'(o_LD_CC_Control), 32'h0);
    step(4'b0001, 4'b0001, 4'b0001, dd);
    i_RST_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(15, 0)), 4'($urandom) | 4'($urandom),
           4'($urandom), {$urandom, $urandom});
    end
    step(4'b0000, 4'b0000, 4'b0000, dd);
    @(posedge i_CLK);
    @(negedge i_CLK);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc3_bus_arbiter.md
# lc3_bus_arbiter

Round-robin arbiter and gate sequencer for the LC-3 16-bit datapath bus. It owns the bus drive enables for up to `N_REQ` bus sources (PC, MARMUX, ALU, MDR), muxes the winning source onto the bus, and raises the condition-code load strobe in the cycle a flag-setting source drives. Its outputs feed the condition-code register's bus input and load-enable directly. It replaces ad-hoc control-store gate decoding wherever several units can request the bus.

## Interface
- `N_REQ`, default 4: number of bus requesters; index 0 = PC, 1 = MARMUX, 2 = ALU, 3 = MDR.
- `MAX_HOLD`, default 4: maximum consecutive cycles one locked owner may hold the bus while others are requesting; must be ≥1.

- `i_CLK`  in  1  single clock; all state updates on the rising edge.
- `i_RST_n`  in  1  asynchronous, active-low reset.
- `i_Req`  in  N_REQ  per-source bus request, level-sensitive.
- `i_Lock`  in  N_REQ  per-source request to keep ownership beyond one cycle.
- `i_SetCC`  in  N_REQ  per-source flag: the value driven must load the condition codes.
- `i_Data`  in  16*N_REQ  packed source data; source k occupies bits [16k+15:16k].
- `o_Gate`  out  N_REQ  one-hot bus enable, registered.
- `o_Grant_Valid`  out  1  high while any `o_Gate` bit is set.
- `o_Bus`  out  16  selected source data; 16'h0000 when no grant.
- `o_LD_CC_Control`  out  1  condition-code load strobe for the current bus cycle.

## Operation
- State: `IDLE`, `OWN`. Registers: `o_Gate`, round-robin pointer `ptr` (log2 N_REQ bits), hold counter `cnt` (holds 0..MAX_HOLD).
- Reset: state `IDLE`, `o_Gate` = 0, `ptr` = 0, `cnt` = 0. Hence `o_Grant_Valid` = 0, `o_Bus` = 16'h0000, `o_LD_CC_Control` = 0.
- Winner selection: the first set bit of `i_Req`, scanning upward from `ptr` and wrapping modulo N_REQ.
- `IDLE`: if `i_Req` = 0, stay. Otherwise load `o_Gate` with the winner, set `cnt` = 1, and go to `OWN`.
- `OWN` with owner k: "continue" = `i_Req[k]` & `i_Lock[k]` & (`cnt` < MAX_HOLD, or no other `i_Req` bit set).
  - Continue: keep `o_Gate`, and increment `cnt`, saturating at MAX_HOLD.
  - Otherwise, release: set `ptr` = k+1 mod N_REQ. If any `i_Req` bit is set, grant the winner (from the new `ptr`) back-to-back and set `cnt` = 1. Else clear `o_Gate` and go to `IDLE`.
- A releasing owner is scanned last, so it regains the bus immediately only if it is the sole requester.
- `o_Bus` = `i_Data` slice of the gated source; the one-hot mux is built as an OR of AND terms.
- `o_LD_CC_Control` = |(`o_Gate` & `i_SetCC`); it is evaluated live every owned cycle.
- `o_Gate` is never multi-hot. An illegal multi-hot state is not reachable from reset.

## Timing
- Grant latency: a request sampled at edge t drives the bus in cycle t→t+1. It is one cycle from an idle bus.
- `o_Bus` and `o_LD_CC_Control` are combinational from registered `o_Gate` and inputs. The CC register captures at the edge ending the bus cycle.
- Withdrawn requests: a request deasserted before it is sampled is never granted. An owner dropping `i_Req` releases at the next edge; the bus is still driven for the current cycle.
- Hold cap: under contention, a locked owner drives at most MAX_HOLD consecutive cycles.
- Simultaneous events: owner release and new requests at the same edge produce a back-to-back handoff with no idle cycle.
- Reset mid-ownership immediately clears `o_Gate`, `o_Bus` and `o_LD_CC_Control`, regardless of the clock.

## Test plan
- Reset, with all requests active during reset: `o_Gate` = 0 and `o_Bus` = 16'h0000. After `i_RST_n` rises with `i_Req` = 4'b1111, the first grant goes to PC (`o_Gate` = 4'b0001) one edge later.
- Round robin: hold `i_Req` = 4'b1111 with `i_Lock` = 0. Required grant sequence: 0001, 0010, 0100, 1000, 0001, with one bus cycle each and no idle gaps.
- Hold cap: with MAX_HOLD = 4, ALU requests with lock while MDR also requests. Required: ALU (0100) owns exactly 4 cycles, then MDR (1000) owns. With ALU as sole requester, it holds indefinitely.
- CC strobe: ALU drives 16'h8000 with `i_SetCC[2]` = 1. Required: `o_Bus` = 16'h8000 and `o_LD_CC_Control` = 1, so the downstream NZP becomes 3'b100. The next MARMUX cycle with `i_SetCC[1]` = 0 gives `o_LD_CC_Control` = 0.
- Owner withdraw: MDR is granted with lock, and `i_Req[3]` drops after 1 cycle with no other requesters. Required: `o_Gate` returns to 0, the state is `IDLE`, and the next grant scans from PC (`ptr` = 0).
- Async reset asserted mid-cycle during a PC grant: `o_Gate`, `o_Bus` and `o_LD_CC_Control` go to 0 before the next clock edge.
